lsm_seq: RTL

LSM_SEQ -- requirements
Module: lsm_seq

---
 rtl/lsm_pkg.sv | 22 ++
 rtl/lsm_prienc.sv | 31 +++
 rtl/lsm_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_pkg
//  Purpose  : Shared types and constants for the load/store-multiple
//             sequencer: FSM state encoding, register count, address step
//             and address width.
//  Revision : 1.0 - initial release
// ============================================================================
package lsm_pkg;

  localparam int LSM_REGS      = 16;  // architectural registers in the mask
  localparam int LSM_ADDR_STEP = 4;   // bytes per transferred word
  localparam int LSM_ADDR_W    = 32;  // address width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lsm_state_t;

endpackage : lsm_pkg
`default_nettype wire

// File: rtl/lsm_prienc.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_prienc
//  Purpose  : Combinational lowest-set-bit priority encoder.
//  Ports    : i_vec [LSM_REGS-1:0] - request vector
//             o_idx [3:0]          - index of the lowest set bit (0 if none)
//             o_any                - at least one bit of i_vec is set
//  Revision : 1.0 - initial release
// ============================================================================
module lsm_prienc
  import lsm_pkg::*;
(
  input  logic [LSM_REGS-1:0] i_vec,
  output logic [3:0]          o_idx,
  output logic                o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = 4'd0;
    o_any = 1'b0;
    for (int i = LSM_REGS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = 4'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule : lsm_prienc
`default_nettype wire

// File: rtl/lsm_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_seq
//  Purpose  : Load/store-multiple sequencer. Breaks a 16-bit register mask
//             into one micro-op per set bit, in ascending register order,
//             stepping the word address by 4 per consumed micro-op.
//  Ports    : clk_i, rst_i (async, active low)
//             start_i, load_i, reglist_i[15:0], base_i[31:0] - request
//             stall_i                                          - downstream hold
//             busy_o, uop_valid_o, uop_reg_o[3:0], uop_load_o,
//             uop_last_o, uop_addr_o[31:0], done_o             - micro-op stream
//             wb_base_o[31:0]  - final base (LSM_SEQ_WRITEBACK_EN only)
//  Config   : `define LSM_SEQ_WRITEBACK_EN to add the wb_base_o port.
//  Revision : 1.0 - initial release
// ============================================================================
module lsm_seq
  import lsm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  load_i,
  input  logic [LSM_REGS-1:0]   reglist_i,
  input  logic [LSM_ADDR_W-1:0] base_i,
  input  logic                  stall_i,
  output logic                  busy_o,
  output logic                  uop_valid_o,
  output logic [3:0]            uop_reg_o,
  output logic                  uop_load_o,
  output logic                  uop_last_o,
  output logic [LSM_ADDR_W-1:0] uop_addr_o,
`ifdef LSM_SEQ_WRITEBACK_EN
  output logic [LSM_ADDR_W-1:0] wb_base_o,
`endif
  output logic                  done_o
);

  lsm_state_t            r_state;
  lsm_state_t            w_state_nxt;
  logic [LSM_REGS-1:0]   r_mask;
  logic [LSM_ADDR_W-1:0] r_addr;
  logic                  r_load;

  logic [3:0]            w_idx;
  logic                  w_any;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_consume;
  logic [LSM_ADDR_W-1:0] w_addr_nxt;

  lsm_prienc u_prienc (
    .i_vec (r_mask),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Exactly one bit left: clearing the lowest set bit leaves zero.
  assign w_last     = w_any && ((r_mask & (r_mask - 16'd1)) == '0);
  assign w_accept   = (r_state == ST_IDLE) && start_i;
  assign w_consume  = (r_state == ST_RUN) && !stall_i;
  assign w_addr_nxt = r_addr + LSM_ADDR_W'(LSM_ADDR_STEP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = (reglist_i != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if (!stall_i && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_addr  <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mask <= reglist_i;
        r_addr <= base_i;
        r_load <= load_i;
      end else if (w_consume) begin
        r_mask <= r_mask & ~(16'd1 << w_idx);
        r_addr <= w_addr_nxt;
      end
    end
  end

`ifdef LSM_SEQ_WRITEBACK_EN
  // The running address already equals base + 4*popcount when the last
  // micro-op is consumed, so the write-back value reuses the step adder.
  // An empty mask enters DONE straight from IDLE with the base unchanged.
  logic [LSM_ADDR_W-1:0] r_wb_base;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_base <= '0;
    end else if (w_accept && (reglist_i == '0)) begin
      r_wb_base <= base_i;
    end else if (w_consume && w_last) begin
      r_wb_base <= w_addr_nxt;
    end
  end

  assign wb_base_o = r_wb_base;
`endif

  // Micro-op fields are forced to zero outside RUN.
  assign busy_o      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign uop_valid_o = (r_state == ST_RUN);
  assign uop_reg_o   = uop_valid_o ? w_idx  : 4'd0;
  assign uop_load_o  = uop_valid_o ? r_load : 1'b0;
  assign uop_last_o  = uop_valid_o ? w_last : 1'b0;
  assign uop_addr_o  = uop_valid_o ? r_addr : '0;
  assign done_o      = (r_state == ST_DONE);

endmodule : lsm_seq
`default_nettype wire
